id_ex_reg: RTL and testbench

- ID/EX pipeline register of the 32-bit RISC-V pipeline.
- Captures the decode-stage control bundle after the bubble-insert control mux, together with the decode-stage datapath values, and presents them to the EX stage.
- Also produces the load-use hazard flag. Hazard logic upstream uses this flag to drive the bubble mux select and to stall IF/ID.
- Provides stall and flush handling and a saturating bubble counter for performance debug.

---
 rtl/id_ex_reg.sv | 168 ++++++++++++++++
 tb/tb_id_ex_reg.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: control/data capture, stall/flush,
// load-use hazard detect and a saturating bubble counter.
package id_ex_pkg;

  typedef struct packed {
    logic [1:0] wbsel;
    logic       memrw;
    logic [3:0] alusel;
    logic       asel;
    logic       bsel;
    logic [2:0] rsel;
    logic [1:0] wsel;
    logic       regwrite;
  } ctrl_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } idx_t;

  localparam logic [1:0] WB_MEM = 2'b01;

endpackage

module id_ex_reg
  import id_ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [1:0]      Wbsel_in,
  input  logic            MemRw_in,
  input  logic [3:0]      ALUsel_in,
  input  logic            Asel_in,
  input  logic            Bsel_in,
  input  logic [2:0]      Rsel_in,
  input  logic [1:0]      Wsel_in,
  input  logic            Regwrite_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic [4:0]      rd_in,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  output logic            valid_out,
  output logic [1:0]      Wbsel_out,
  output logic            MemRw_out,
  output logic [3:0]      ALUsel_out,
  output logic            Asel_out,
  output logic            Bsel_out,
  output logic [2:0]      Rsel_out,
  output logic [1:0]      Wsel_out,
  output logic            Regwrite_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] rs1_data_out,
  output logic [XLEN-1:0] rs2_data_out,
  output logic [XLEN-1:0] imm_out,
  output logic [4:0]      rs1_out,
  output logic [4:0]      rs2_out,
  output logic [4:0]      rd_out,
  output logic            load_use_hazard,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
  } data_t;

  ctrl_t ctrl_d, ctrl_q;
  data_t data_d, data_q;
  idx_t  idx_d,  idx_q;
  logic  valid_q;
  logic  bubble_ev;
  logic  cnt_sat;

  // Non-instructions must never carry side-effecting control into EX.
  always_comb begin
    ctrl_d          = '0;
    if (in_valid) begin
      ctrl_d.wbsel    = Wbsel_in;
      ctrl_d.memrw    = MemRw_in;
      ctrl_d.alusel   = ALUsel_in;
      ctrl_d.asel     = Asel_in;
      ctrl_d.bsel     = Bsel_in;
      ctrl_d.rsel     = Rsel_in;
      ctrl_d.wsel     = Wsel_in;
      ctrl_d.regwrite = Regwrite_in;
    end
  end

  always_comb begin
    data_d.pc       = pc_in;
    data_d.rs1_data = rs1_data_in;
    data_d.rs2_data = rs2_data_in;
    data_d.imm      = imm_in;
    idx_d.rs1       = rs1_in;
    idx_d.rs2       = rs2_in;
    idx_d.rd        = rd_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
    end else if (!stall) begin
      valid_q <= in_valid;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  // Flush wins over stall, so a flushed edge always counts.
  assign bubble_ev = flush | (~stall & ~in_valid);
  assign cnt_sat   = &bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (bubble_ev && !cnt_sat) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  assign valid_out    = valid_q;
  assign Wbsel_out    = ctrl_q.wbsel;
  assign MemRw_out    = ctrl_q.memrw;
  assign ALUsel_out   = ctrl_q.alusel;
  assign Asel_out     = ctrl_q.asel;
  assign Bsel_out     = ctrl_q.bsel;
  assign Rsel_out     = ctrl_q.rsel;
  assign Wsel_out     = ctrl_q.wsel;
  assign Regwrite_out = ctrl_q.regwrite;
  assign pc_out       = data_q.pc;
  assign rs1_data_out = data_q.rs1_data;
  assign rs2_data_out = data_q.rs2_data;
  assign imm_out      = data_q.imm;
  assign rs1_out      = idx_q.rs1;
  assign rs2_out      = idx_q.rs2;
  assign rd_out       = idx_q.rd;

  assign load_use_hazard = valid_q
                         & (ctrl_q.wbsel == WB_MEM)
                         & ctrl_q.regwrite
                         & (idx_q.rd != 5'd0)
                         & ((idx_q.rd == id_rs1)
                          | (idx_q.rd == id_rs2));

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed + random bench for id_ex_reg against a
// cycle-level model of the stage rules.
module tb_id_ex_reg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic clk = 1'b0;
  logic rst_n, stall, flush, in_valid;
  logic [1:0] Wbsel_in, Wsel_in;
  logic MemRw_in, Asel_in, Bsel_in, Regwrite_in;
  logic [3:0] ALUsel_in;
  logic [2:0] Rsel_in;
  logic [XLEN-1:0] pc_in, rs1_data_in, rs2_data_in, imm_in;
  logic [4:0] rs1_in, rs2_in, rd_in, id_rs1, id_rs2;

  logic valid_out, MemRw_out, Asel_out, Bsel_out, Regwrite_out;
  logic [1:0] Wbsel_out, Wsel_out;
  logic [3:0] ALUsel_out;
  logic [2:0] Rsel_out;
  logic [XLEN-1:0] pc_out, rs1_data_out, rs2_data_out, imm_out;
  logic [4:0] rs1_out, rs2_out, rd_out;
  logic load_use_hazard;
  logic [CNT_W-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  // model state
  logic        m_valid;
  logic [1:0]  m_wb;
  logic        m_rw;
  logic [14:0] m_ctrl;
  logic [127:0] m_data;
  logic [14:0] m_idx;
  int          m_cnt;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .Wbsel_in(Wbsel_in),
    .MemRw_in(MemRw_in), .ALUsel_in(ALUsel_in),
    .Asel_in(Asel_in), .Bsel_in(Bsel_in),
    .Rsel_in(Rsel_in), .Wsel_in(Wsel_in),
    .Regwrite_in(Regwrite_in), .pc_in(pc_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .imm_in(imm_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .rd_in(rd_in), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .valid_out(valid_out), .Wbsel_out(Wbsel_out),
    .MemRw_out(MemRw_out), .ALUsel_out(ALUsel_out),
    .Asel_out(Asel_out), .Bsel_out(Bsel_out),
    .Rsel_out(Rsel_out), .Wsel_out(Wsel_out),
    .Regwrite_out(Regwrite_out), .pc_out(pc_out),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .imm_out(imm_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .rd_out(rd_out), .load_use_hazard(load_use_hazard),
    .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] in_ctrl();
    return {Wbsel_in, MemRw_in, ALUsel_in, Asel_in, Bsel_in,
            Rsel_in, Wsel_in, Regwrite_in};
  endfunction

  function automatic logic m_hazard();
    logic [4:0] rd;
    rd = m_idx[4:0];
    if (!m_valid || m_wb != 2'b01 || !m_rw) return 1'b0;
    if (rd == 5'd0) return 1'b0;
    return (rd == id_rs1) || (rd == id_rs2);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = '0; m_data = '0;
    m_idx = '0; m_cnt = 0; m_wb = '0; m_rw = 1'b0;
  endtask

  task automatic model_edge();
    if (flush) begin
      m_valid = 1'b0; m_ctrl = '0; m_data = '0; m_idx = '0;
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end else if (!stall) begin
      m_valid = in_valid;
      m_ctrl  = in_valid ? in_ctrl() : 15'd0;
      m_data  = {pc_in, rs1_data_in, rs2_data_in, imm_in};
      m_idx   = {rs1_in, rs2_in, rd_in};
      if (!in_valid) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end
    m_wb = m_ctrl[14:13];
    m_rw = m_ctrl[0];
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 128'(valid_out), 128'(m_valid));
    chk({tag, ".ctrl"},
        128'({Wbsel_out, MemRw_out, ALUsel_out, Asel_out,
              Bsel_out, Rsel_out, Wsel_out, Regwrite_out}),
        128'(m_ctrl));
    chk({tag, ".data"},
        {pc_out, rs1_data_out, rs2_data_out, imm_out}, m_data);
    chk({tag, ".idx"},
        128'({rs1_out, rs2_out, rd_out}), 128'(m_idx));
    chk({tag, ".haz"}, 128'(load_use_hazard), 128'(m_hazard()));
    chk({tag, ".cnt"}, 128'(bubble_cnt), 128'(m_cnt));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; in_valid = 0;
    Wbsel_in = 0; MemRw_in = 0; ALUsel_in = 0; Asel_in = 0;
    Bsel_in = 0; Rsel_in = 0; Wsel_in = 0; Regwrite_in = 0;
    pc_in = 0; rs1_data_in = 0; rs2_data_in = 0; imm_in = 0;
    rs1_in = 0; rs2_in = 0; rd_in = 0; id_rs1 = 0; id_rs2 = 0;
  endtask

  task automatic rand_inputs();
    logic [31:0] r;
    r = $urandom;
    stall = (r[3:0] < 4'd3);
    flush = (r[7:4] < 4'd2);
    in_valid = (r[11:8] > 4'd3);
    Wbsel_in = r[13:12]; MemRw_in = r[14];
    ALUsel_in = r[18:15]; Asel_in = r[19]; Bsel_in = r[20];
    Rsel_in = r[23:21]; Wsel_in = r[25:24];
    Regwrite_in = r[26];
    pc_in = $urandom; rs1_data_in = $urandom;
    rs2_data_in = $urandom; imm_in = $urandom;
    rs1_in = 5'($urandom_range(0, 7));
    rs2_in = 5'($urandom_range(0, 7));
    rd_in  = 5'($urandom_range(0, 7));
    id_rs1 = 5'($urandom_range(0, 7));
    id_rs2 = 5'($urandom_range(0, 7));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    do_reset();

    // normal flow
    in_valid = 1; pc_in = 32'h100; imm_in = 32'hFFFF_FFF0;
    Wbsel_in = 2'b00; Regwrite_in = 1;
    tick("normal");
    chk("normal.pc", 128'(pc_out), 128'h100);
    chk("normal.imm", 128'(imm_out), 128'hFFFF_FFF0);
    chk("normal.rw", 128'(Regwrite_out), 128'd1);

    // stall x3 then stall+flush
    pc_in = 32'h104;
    tick("pc104");
    stall = 1; pc_in = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall.pc", 128'(pc_out), 128'h104);
    end
    flush = 1;
    tick("stflush");
    chk("stflush.pc", 128'(pc_out), 128'h0);
    chk("stflush.cnt", 128'(bubble_cnt), 128'd1);
    stall = 0; flush = 0;

    // load-use
    in_valid = 1; Wbsel_in = 2'b01; Regwrite_in = 1;
    rd_in = 5'd5; id_rs1 = 5'd0; id_rs2 = 5'd5;
    tick("lu");
    chk("lu.haz", 128'(load_use_hazard), 128'd1);
    stall = 1; rd_in = 5'd9;
    tick("lu_hold");
    chk("lu_hold.haz", 128'(load_use_hazard), 128'd1);
    stall = 0; rd_in = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    tick("lu_rd0");
    chk("lu_rd0.haz", 128'(load_use_hazard), 128'd0);
    rd_in = 5'd5; Wbsel_in = 2'b00; id_rs2 = 5'd5;
    tick("lu_alu");
    chk("lu_alu.haz", 128'(load_use_hazard), 128'd0);

    // bubble via in_valid=0
    in_valid = 0; Regwrite_in = 1; MemRw_in = 1;
    rs1_data_in = 32'hDEAD_BEEF;
    tick("bub");
    chk("bub.rw", 128'(Regwrite_out), 128'd0);
    chk("bub.mem", 128'(MemRw_out), 128'd0);
    chk("bub.rs1d", 128'(rs1_data_out), 128'hDEAD_BEEF);
    chk("bub.cnt", 128'(bubble_cnt), 128'd2);

    // reset mid-stream
    idle_inputs();
    in_valid = 1; ALUsel_in = 4'h3; rd_in = 5'd7;
    tick("pre_rst");
    #2;
    do_reset();
    chk("rst.alu", 128'(ALUsel_out), 128'd0);
    chk("rst.rd", 128'(rd_out), 128'd0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      tick("rand");
    end

    // saturation
    idle_inputs();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick("sat");
    end
    chk("sat.cnt", 128'(bubble_cnt), 128'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
